// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard controller
//
// Purpose : producer scoreboard tag, forwarding-select encoding and the
//           saturating Tnew decrement used when a tag advances one stage.
// Ports   : none (package).
package hazard_pkg;

    localparam int HZ_AW = 5;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] anew;
        logic [1:0]       tnew;
    } hz_tag_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_DM   = 2'd2,
        FWD_RW   = 2'd3
    } fwd_sel_e;

    // Cycles-until-ready shrinks by one per stage but never goes negative.
    function automatic logic [1:0] sat_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hz_match.sv
// rtl/hz_match.sv - youngest-producer match for one consumer source register
//
// Purpose : finds the youngest valid producer tag (EX, then DM, then RW)
//           writing the requested register; register 0 never matches.
// Ports   : ause   in  consumer source register
//           exTag  in  producer tag in EX (tie to zero for no EX slot)
//           dmTag  in  producer tag in DM
//           rwTag  in  producer tag in RW
//           hit    out a producer was found
//           stage  out stage holding that producer
//           tnew   out that producer's remaining cycles until its result exists
module hz_match
    import hazard_pkg::*;
(
    input  logic [HZ_AW-1:0] ause,
    input  hz_tag_t          exTag,
    input  hz_tag_t          dmTag,
    input  hz_tag_t          rwTag,
    output logic             hit,
    output fwd_sel_e         stage,
    output logic [1:0]       tnew
);

    always_comb begin
        hit   = 1'b0;
        stage = FWD_NONE;
        tnew  = 2'd0;
        if (ause != '0) begin
            // Priority order keeps the youngest write visible, hiding older ones.
            if (exTag.valid && exTag.anew == ause) begin
                hit   = 1'b1;
                stage = FWD_EX;
                tnew  = exTag.tnew;
            end else if (dmTag.valid && dmTag.anew == ause) begin
                hit   = 1'b1;
                stage = FWD_DM;
                tnew  = dmTag.tnew;
            end else if (rwTag.valid && rwTag.anew == ause) begin
                hit   = 1'b1;
                stage = FWD_RW;
                tnew  = rwTag.tnew;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forward controller for the 5-stage pipeline
//
// Purpose : tracks in-flight producers in EX/DM/RW, stalls the RR consumer
//           while an operand is not yet available, and drives forwarding
//           selects for RR and EX operands.
// Ports   : clk, reset (async, active-low)
//           rr_valid, rr_ause0/1, rr_tuse0/1, rr_anew, rr_tnew  RR instruction
//           stall                   freeze PC/IF2RR, bubble RR2EX
//           fwd_rr_sel0/1           RR operand source (0 GRF,1 EX,2 DM,3 RW)
//           fwd_ex_sel0/1           EX operand source (0 RR2EX,2 DM,3 RW)
//           stall_cnt               stalled-cycle counter (HAZARD_STAT_EN only)
// Config  : define HAZARD_STAT_EN to add the stall_cnt port and counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW = HZ_AW
`ifdef HAZARD_STAT_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rr_valid,
    input  logic [AW-1:0] rr_ause0,
    input  logic [1:0]    rr_tuse0,
    input  logic [AW-1:0] rr_ause1,
    input  logic [1:0]    rr_tuse1,
    input  logic [AW-1:0] rr_anew,
    input  logic [1:0]    rr_tnew,
    output logic          stall,
    output logic [1:0]    fwd_rr_sel0,
    output logic [1:0]    fwd_rr_sel1,
    output logic [1:0]    fwd_ex_sel0,
    output logic [1:0]    fwd_ex_sel1
`ifdef HAZARD_STAT_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    localparam hz_tag_t NO_TAG = '0;

    hz_tag_t       exTag, dmTag, rwTag;
    logic [AW-1:0] exAuse0, exAuse1;

    logic          rrHit0, rrHit1, exHit0, exHit1;
    fwd_sel_e      rrStage0, rrStage1, exStage0, exStage1;
    logic [1:0]    rrTnew0, rrTnew1, exTnew0, exTnew1;

    hz_match uRr0 (.ause(rr_ause0), .exTag(exTag), .dmTag(dmTag), .rwTag(rwTag),
                   .hit(rrHit0), .stage(rrStage0), .tnew(rrTnew0));
    hz_match uRr1 (.ause(rr_ause1), .exTag(exTag), .dmTag(dmTag), .rwTag(rwTag),
                   .hit(rrHit1), .stage(rrStage1), .tnew(rrTnew1));

    // The EX consumer is itself the instruction in EX, so only DM/RW can feed it.
    hz_match uEx0 (.ause(exAuse0), .exTag(NO_TAG), .dmTag(dmTag), .rwTag(rwTag),
                   .hit(exHit0), .stage(exStage0), .tnew(exTnew0));
    hz_match uEx1 (.ause(exAuse1), .exTag(NO_TAG), .dmTag(dmTag), .rwTag(rwTag),
                   .hit(exHit1), .stage(exStage1), .tnew(exTnew1));

    // Operands are consumed in EX at the latest, so any Tuse >= 1 behaves as 1.
    logic tuse0, tuse1;
    assign tuse0 = |rr_tuse0;
    assign tuse1 = |rr_tuse1;

    assign stall = rr_valid &
                   ((rrHit0 & (rrTnew0 > {1'b0, tuse0})) |
                    (rrHit1 & (rrTnew1 > {1'b0, tuse1})));

    assign fwd_rr_sel0 = (rrHit0 && rrTnew0 == 2'd0 && !stall) ? rrStage0 : FWD_NONE;
    assign fwd_rr_sel1 = (rrHit1 && rrTnew1 == 2'd0 && !stall) ? rrStage1 : FWD_NONE;
    assign fwd_ex_sel0 = (exHit0 && exTnew0 == 2'd0) ? exStage0 : FWD_NONE;
    assign fwd_ex_sel1 = (exHit1 && exTnew1 == 2'd0) ? exStage1 : FWD_NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exTag   <= '0;
            dmTag   <= '0;
            rwTag   <= '0;
            exAuse0 <= '0;
            exAuse1 <= '0;
        end else begin
            // Writes to register 0 are stored invalid so they never match.
            if (stall || !rr_valid || rr_anew == '0) begin
                exTag <= '0;
            end else begin
                exTag <= '{valid: 1'b1, anew: rr_anew, tnew: sat_dec(rr_tnew)};
            end
            dmTag <= '{valid: exTag.valid, anew: exTag.anew, tnew: sat_dec(exTag.tnew)};
            rwTag <= '{valid: dmTag.valid, anew: dmTag.anew, tnew: sat_dec(dmTag.tnew)};
            if (!stall && rr_valid) begin
                exAuse0 <= rr_ause0;
                exAuse1 <= rr_ause1;
            end else begin
                exAuse0 <= '0;
                exAuse1 <= '0;
            end
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    // No stall statistics in this build.
`endif

endmodule
